// File: rtl/phy_rx_lanes.sv
// Multi-lane serial receive: per-lane comma alignment, byte packing into words,
// per-lane FIFOs and a strict round-robin unstriper into one word stream.
//
//   state | meaning
//   HUNT  | searching every bit position for a comma
//   ALIGN | comma seen; confirming COMMA_COUNT commas on 8-bit boundaries
//   SYNC  | locked; bytes on boundaries are packed into words
module phy_rx_lanes #(
   parameter int         LANES       = 2,
   parameter int         WORD_BYTES  = 4,
   parameter logic [7:0] COMMA       = 8'hBC,
   parameter int         COMMA_COUNT = 4,
   parameter int         FIFO_DEPTH  = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    valid,
   input  logic [LANES-1:0]        data_serie,
   output logic [8*WORD_BYTES-1:0] data_out,
   output logic                    valid_out,
   output logic [LANES-1:0]        sync_ok,
   output logic [LANES-1:0]        overflow,
   output logic [LANES-1:0]        frame_err
);

   localparam int W   = 8 * WORD_BYTES;
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int RRW = (LANES > 1) ? $clog2(LANES) : 1;

   typedef enum logic [1:0] {HUNT, ALIGN, SYNC} state_t;

   state_t     state_q   [LANES];
   state_t     state_n   [LANES];
   logic [7:0] sr_q      [LANES];
   logic [7:0] sr_n      [LANES];
   logic [2:0] bitcnt_q  [LANES];
   logic [2:0] bitcnt_n  [LANES];
   logic [3:0] ccnt_q    [LANES];
   logic [3:0] ccnt_n    [LANES];
   logic [2:0] bcnt_q    [LANES];
   logic [2:0] bcnt_n    [LANES];
   logic [W-1:0] pack_q  [LANES];
   logic [W-1:0] pack_n  [LANES];
   logic [W-1:0] wr_word_q [LANES];
   logic [W-1:0] wr_word_n [LANES];
   logic [LANES-1:0] wr_en_q, wr_en_n, ferr_n, pop, wr_ok;

   logic [W-1:0]  mem   [LANES][FIFO_DEPTH];
   logic [AW-1:0] wptr_q [LANES];
   logic [AW-1:0] rptr_q [LANES];
   logic [AW:0]   cnt_q  [LANES];
   logic [RRW-1:0] rr_q;

   always_comb begin
      state_n   = state_q;
      sr_n      = sr_q;
      bitcnt_n  = bitcnt_q;
      ccnt_n    = ccnt_q;
      bcnt_n    = bcnt_q;
      pack_n    = pack_q;
      wr_word_n = wr_word_q;
      wr_en_n   = '0;
      ferr_n    = '0;
      for (int i = 0; i < LANES; i++) begin
         if (valid) begin
            sr_n[i] = {sr_q[i][6:0], data_serie[i]};
            case (state_q[i])
               HUNT: begin
                  if (sr_n[i] == COMMA) begin
                     bitcnt_n[i] = 3'd0;
                     ccnt_n[i]   = 4'd1;
                     state_n[i]  = (COMMA_COUNT == 1) ? SYNC : ALIGN;
                  end
               end
               ALIGN: begin
                  bitcnt_n[i] = bitcnt_q[i] + 3'd1;
                  if (bitcnt_q[i] == 3'd7) begin
                     if (sr_n[i] == COMMA) begin
                        ccnt_n[i] = ccnt_q[i] + 4'd1;
                        if (ccnt_q[i] + 4'd1 == 4'(COMMA_COUNT))
                           state_n[i] = SYNC;
                     end else begin
                        ccnt_n[i]  = 4'd0;
                        state_n[i] = HUNT;
                     end
                  end
               end
               SYNC: begin
                  bitcnt_n[i] = bitcnt_q[i] + 3'd1;
                  if (bitcnt_q[i] == 3'd7) begin
                     if (sr_n[i] == COMMA) begin
                        // an idle comma mid-word means the partial word is garbage
                        if (bcnt_q[i] != 3'd0)
                           ferr_n[i] = 1'b1;
                        bcnt_n[i] = 3'd0;
                     end else begin
                        pack_n[i] = W'({pack_q[i], sr_n[i]});
                        if (bcnt_q[i] == 3'(WORD_BYTES - 1)) begin
                           wr_en_n[i]   = 1'b1;
                           wr_word_n[i] = W'({pack_q[i], sr_n[i]});
                           bcnt_n[i]    = 3'd0;
                        end else begin
                           bcnt_n[i] = bcnt_q[i] + 3'd1;
                        end
                     end
                  end
               end
               default: state_n[i] = HUNT;
            endcase
         end
      end
   end

   always_comb begin
      pop     = '0;
      wr_ok   = '0;
      sync_ok = '0;
      for (int i = 0; i < LANES; i++) begin
         pop[i]     = (rr_q == RRW'(i)) && (cnt_q[i] != '0);
         // a pop in the same cycle frees a slot in a full FIFO
         wr_ok[i]   = wr_en_q[i] && ((cnt_q[i] != (AW+1)'(FIFO_DEPTH)) || pop[i]);
         sync_ok[i] = (state_q[i] == SYNC);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < LANES; i++) begin
            state_q[i]   <= HUNT;
            sr_q[i]      <= '0;
            bitcnt_q[i]  <= '0;
            ccnt_q[i]    <= '0;
            bcnt_q[i]    <= '0;
            pack_q[i]    <= '0;
            wr_word_q[i] <= '0;
            wptr_q[i]    <= '0;
            rptr_q[i]    <= '0;
            cnt_q[i]     <= '0;
         end
         wr_en_q   <= '0;
         rr_q      <= '0;
         data_out  <= '0;
         valid_out <= 1'b0;
         overflow  <= '0;
         frame_err <= '0;
      end else begin
         state_q   <= state_n;
         sr_q      <= sr_n;
         bitcnt_q  <= bitcnt_n;
         ccnt_q    <= ccnt_n;
         bcnt_q    <= bcnt_n;
         pack_q    <= pack_n;
         wr_word_q <= wr_word_n;
         wr_en_q   <= wr_en_n;
         frame_err <= ferr_n;
         overflow  <= wr_en_q & ~wr_ok;
         for (int i = 0; i < LANES; i++) begin
            if (wr_ok[i])
               wptr_q[i] <= wptr_q[i] + 1'b1;
            if (pop[i])
               rptr_q[i] <= rptr_q[i] + 1'b1;
            if (wr_ok[i] && !pop[i])
               cnt_q[i] <= cnt_q[i] + 1'b1;
            else if (!wr_ok[i] && pop[i])
               cnt_q[i] <= cnt_q[i] - 1'b1;
         end
         if (|pop) begin
            data_out  <= mem[rr_q][rptr_q[rr_q]];
            valid_out <= 1'b1;
            rr_q      <= (rr_q == RRW'(LANES - 1)) ? '0 : rr_q + 1'b1;
         end else begin
            valid_out <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < LANES; i++)
         if (wr_ok[i])
            mem[i][wptr_q[i]] <= wr_word_q[i];
   end

endmodule

// File: tb/tb_phy_rx_lanes.sv
// Directed bench for phy_rx_lanes (2 lanes, 4-byte words): alignment, packing,
// framing errors, FIFO overflow, round-robin order and reset flushing.
module tb_phy_rx_lanes;

   localparam logic [7:0] K = 8'hBC;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        valid = 1'b0;
   logic [1:0]  data_serie = 2'b00;
   logic [31:0] data_out;
   logic        valid_out;
   logic [1:0]  sync_ok, overflow, frame_err;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int t_last = 0;
   int t_mark = 0;

   logic [31:0] outq[$];
   int          cycq[$];
   int ferr0 = 0, ferr1 = 0, ovf0 = 0, ovf1 = 0, ferr_cyc = -1, ovf_cyc = -1;

   phy_rx_lanes #(
      .LANES(2), .WORD_BYTES(4), .COMMA(8'hBC), .COMMA_COUNT(4), .FIFO_DEPTH(4)
   ) dut (
      .clk(clk), .reset(reset), .valid(valid), .data_serie(data_serie),
      .data_out(data_out), .valid_out(valid_out), .sync_ok(sync_ok),
      .overflow(overflow), .frame_err(frame_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (valid_out) begin
         outq.push_back(data_out);
         cycq.push_back(cyc);
      end
      if (frame_err[0]) begin ferr0++; ferr_cyc = cyc; end
      if (frame_err[1]) ferr1++;
      if (overflow[0]) begin ovf0++; ovf_cyc = cyc; end
      if (overflow[1]) ovf1++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] qget(input int idx);
      return (idx < outq.size()) ? outq[idx] : 32'hDEAD_BEEF;
   endfunction

   function automatic int cget(input int idx);
      return (idx < cycq.size()) ? cycq[idx] : -1;
   endfunction

   task automatic clear_mon();
      outq.delete();
      cycq.delete();
      ferr0 = 0; ferr1 = 0; ovf0 = 0; ovf1 = 0; ferr_cyc = -1; ovf_cyc = -1;
   endtask

   task automatic shift1(input logic [1:0] b);
      data_serie = b;
      valid = 1'b1;
      @(posedge clk); #1;
      t_last = cyc;
   endtask

   task automatic send2(input logic [7:0] b0, input logic [7:0] b1);
      for (int k = 7; k >= 0; k--) shift1({b1[k], b0[k]});
   endtask

   task automatic freeze(input int n);
      valid = 1'b0;
      data_serie = 2'b11;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic reset_on(input int n);
      reset = 1'b1;
      valid = 1'b1;
      repeat (n) begin
         data_serie = 2'($urandom);
         @(posedge clk); #1;
      end
   endtask

   task automatic reset_off();
      reset = 1'b0;
      valid = 1'b0;
      clear_mon();
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_dout"}, data_out, 32'h0);
      chk({tag, "_vout"}, {31'd0, valid_out}, 32'd0);
      chk({tag, "_sync"}, {30'd0, sync_ok}, 32'd0);
      chk({tag, "_ovf"},  {30'd0, overflow}, 32'd0);
      chk({tag, "_ferr"}, {30'd0, frame_err}, 32'd0);
   endtask

   task automatic sync_both();
      repeat (4) send2(K, K);
   endtask

   initial begin
      // reset state, then 3 commas and garbage must not lock lane 0
      reset_on(4);
      check_reset_outputs("t1_rst");
      reset_off();
      repeat (3) send2(K, 8'h00);
      chk("t1_sync_3commas", {30'd0, sync_ok}, 32'd0);
      send2(8'h00, 8'h00);
      send2(8'h00, 8'h00);
      chk("t1_sync_garbage", {30'd0, sync_ok}, 32'd0);

      // sync on the 4th comma, then one word per lane on consecutive cycles
      reset_on(2);
      reset_off();
      repeat (3) send2(K, K);
      chk("t2_sync_after3", {30'd0, sync_ok}, 32'd0);
      send2(K, K);
      chk("t2_sync_after4", {30'd0, sync_ok}, 32'd3);
      send2(8'h11, 8'h55);
      send2(8'h22, 8'h66);
      send2(8'h33, 8'h77);
      send2(8'h44, 8'h88);
      t_mark = t_last;
      send2(K, K);
      send2(K, K);
      chk("t2_count", outq.size(), 32'd2);
      chk("t2_word0", qget(0), 32'h11223344);
      chk("t2_word1", qget(1), 32'h55667788);
      chk("t2_lat0", cget(0), t_mark + 2);
      chk("t2_lat1", cget(1), t_mark + 3);

      // 3-bit misalignment, plus a valid=0 freeze inside the word
      reset_on(2);
      reset_off();
      shift1(2'b11);
      shift1(2'b11);
      shift1(2'b00);
      sync_both();
      chk("t3_sync", {30'd0, sync_ok}, 32'd3);
      send2(8'hAA, K);
      freeze(5);
      send2(8'hBB, K);
      send2(8'hCC, K);
      send2(8'hDD, K);
      send2(K, K);
      send2(K, K);
      chk("t3_count", outq.size(), 32'd1);
      chk("t3_word", qget(0), 32'hAABBCCDD);

      // comma inside a word discards the partial word
      reset_on(2);
      reset_off();
      sync_both();
      send2(8'h01, K);
      send2(8'h02, K);
      send2(K, K);
      t_mark = t_last;
      send2(8'h03, K);
      send2(8'h04, K);
      send2(8'h05, K);
      send2(8'h06, K);
      send2(K, K);
      send2(K, K);
      chk("t4_ferr0_pulses", ferr0, 32'd1);
      chk("t4_ferr0_cycle", ferr_cyc, t_mark);
      chk("t4_ferr1_pulses", ferr1, 32'd0);
      chk("t4_count", outq.size(), 32'd1);
      chk("t4_word", qget(0), 32'h03040506);

      // lane 1 idle: lane 0 fills its FIFO and the 6th word overflows
      reset_on(2);
      reset_off();
      sync_both();
      for (int w = 1; w <= 6; w++)
         for (int b = 0; b < 4; b++)
            send2(8'(w * 16 + b), K);
      t_mark = t_last;
      send2(K, K);
      send2(K, K);
      chk("t5_count_before", outq.size(), 32'd1);
      chk("t5_word1", qget(0), 32'h10111213);
      chk("t5_ovf0_pulses", ovf0, 32'd1);
      chk("t5_ovf0_cycle", ovf_cyc, t_mark + 1);
      chk("t5_ovf1_pulses", ovf1, 32'd0);
      send2(K, 8'hC1);
      send2(K, 8'hC2);
      send2(K, 8'hC3);
      send2(K, 8'hC4);
      send2(K, K);
      send2(K, K);
      chk("t5_count_after", outq.size(), 32'd3);
      chk("t5_lane1_word", qget(1), 32'hC1C2C3C4);
      chk("t5_word2", qget(2), 32'h20212223);
      chk("t5_ferr0", ferr0, 32'd0);

      // mid-word reset with stale words still buffered in lane 0
      send2(8'hDE, K);
      send2(8'hAD, K);
      reset_on(2);
      check_reset_outputs("t6_rst");
      reset_off();
      sync_both();
      send2(8'h31, 8'h41);
      send2(8'h32, 8'h42);
      send2(8'h33, 8'h43);
      send2(8'h34, 8'h44);
      send2(K, K);
      send2(K, K);
      chk("t6_count", outq.size(), 32'd2);
      chk("t6_word0", qget(0), 32'h31323334);
      chk("t6_word1", qget(1), 32'h41424344);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
